comple2_to_signmag_serial: RTL and testbench

- Inverse of the 16-bit two's-complement unit: takes a WIDTH-bit two's-complement word and returns sign plus unsigned magnitude.
- Bit-serial, one bit per clock, LSB first.
- Uses the same per-bit complement/carry rule: r = ~a ^ c, c' = ~a & c, with carry-in 1 when the sign is set.
- Valid/ready on both sides; sits between the ALU result bus and display/BCD logic that needs sign-magnitude.

---
 rtl/comple2_to_signmag_serial_if.sv | 15 +
 rtl/comple2_to_signmag_serial.sv | 90 +++++++++
 tb/tb_comple2_to_signmag_serial.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/comple2_to_signmag_serial_if.sv
// comple2_to_signmag_serial_if: valid/ready bus carrying a two's-complement word in and sign-magnitude out
interface comple2_to_signmag_serial_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [WIDTH-1:0] out_mag;
    logic             out_minneg;
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_sign, out_mag, out_minneg);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_sign, out_mag, out_minneg);
endinterface

// File: rtl/comple2_to_signmag_serial.sv
// comple2_to_signmag_serial: bit-serial, LSB-first two's-complement to sign-magnitude converter.
// Define COMPLE2_SIGNMAG_FAST_EN to convert combinationally at acceptance (IDLE -> DONE, busy stays 0).
module comple2_to_signmag_serial #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic rst,
    comple2_to_signmag_serial_if.slave bus,
    output logic busy
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t           r_state;
    logic [WIDTH-1:0] r_sr, r_mag, r_out_mag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry, r_sign, r_minneg;
    logic             r_in_ready, r_out_valid, r_out_sign, r_out_minneg, r_busy;
    logic             w_bit;
    logic             w_minneg;
    assign w_bit    = r_sign ? (~r_sr[0] ^ r_carry) : r_sr[0];
    assign w_minneg = bus.in_data == {1'b1, {(WIDTH-1){1'b0}}};
    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_sign   = r_out_sign;
    assign bus.out_mag    = r_out_mag;
    assign bus.out_minneg = r_out_minneg;
    assign busy           = r_busy;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_sr         <= '0;
            r_mag        <= '0;
            r_cnt        <= '0;
            r_carry      <= 1'b0;
            r_sign       <= 1'b0;
            r_minneg     <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_sign   <= 1'b0;
            r_out_mag    <= '0;
            r_out_minneg <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_in_ready <= 1'b0;
`ifdef COMPLE2_SIGNMAG_FAST_EN
                    r_state      <= DONE;
                    r_out_valid  <= 1'b1;
                    r_out_sign   <= bus.in_data[WIDTH-1];
                    r_out_mag    <= bus.in_data[WIDTH-1] ? ~bus.in_data + 1'b1 : bus.in_data;
                    r_out_minneg <= w_minneg;
`else
                    r_state  <= CONV;
                    r_busy   <= 1'b1;
                    r_sr     <= bus.in_data;
                    r_sign   <= bus.in_data[WIDTH-1];
                    r_carry  <= bus.in_data[WIDTH-1];
                    r_minneg <= w_minneg;
                    r_cnt    <= '0;
`endif
                end
                CONV: begin
                    // carry only propagates on the negate path; final carry-out is dropped
                    r_carry <= r_sign ? (~r_sr[0] & r_carry) : r_carry;
                    r_sr    <= r_sr >> 1;
                    r_mag   <= {w_bit, r_mag[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_out_sign   <= r_sign;
                        r_out_mag    <= {w_bit, r_mag[WIDTH-1:1]};
                        r_out_minneg <= r_minneg;
                    end
                end
                DONE: if (bus.out_ready) begin
                    r_state      <= IDLE;
                    r_in_ready   <= 1'b1;
                    r_out_valid  <= 1'b0;
                    r_out_sign   <= 1'b0;
                    r_out_mag    <= '0;
                    r_out_minneg <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_comple2_to_signmag_serial.sv
// tb_comple2_to_signmag_serial: directed + random scoreboard bench for comple2_to_signmag_serial.
// Honours COMPLE2_SIGNMAG_FAST_EN for expected latency and busy.
module tb_comple2_to_signmag_serial;
    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
`ifdef COMPLE2_SIGNMAG_FAST_EN
    localparam int       LAT      = 1;
    localparam logic     BUSY_EXP = 1'b0;
`else
    localparam int       LAT      = WIDTH + 1;
    localparam logic     BUSY_EXP = 1'b1;
`endif
    typedef struct packed {
        logic             s;
        logic [WIDTH-1:0] m;
        logic             n;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    res_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;
    comple2_to_signmag_serial_if #(.WIDTH(WIDTH)) bus();
    comple2_to_signmag_serial #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );
    always #5 clk = ~clk;
    function automatic res_t model(logic [WIDTH-1:0] d);
        res_t r;
        r.s = d[WIDTH-1];
        r.m = d[WIDTH-1] ? WIDTH'((1 << WIDTH) - int'(d)) : d;
        r.n = (int'(d) == (1 << (WIDTH-1)));
        return r;
    endfunction
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // hold in_valid until in_ready, then let the accepting edge pass
    task automatic send(logic [WIDTH-1:0] d);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(n < 100), 1);
        sb.push_back(model(d));
        step();
        bus.in_valid = 1'b0;
    endtask
    task automatic recv(string tag);
        int   n = 1;
        res_t e;
        chk({tag, "_busy"}, 32'(busy), 32'(BUSY_EXP));
        while (!bus.out_valid && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_sbq"}, 32'(sb.size() > 0), 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_sign"}, 32'(bus.out_sign), 32'(e.s));
        chk({tag, "_mag"}, 32'(bus.out_mag), 32'(e.m));
        chk({tag, "_minneg"}, 32'(bus.out_minneg), 32'(e.n));
        chk({tag, "_inrdy_done"}, 32'(bus.in_ready), 0);
        if (bus.out_ready) begin
            step();
            chk({tag, "_vld_drop"}, 32'(bus.out_valid), 0);
            chk({tag, "_mag_zero"}, 32'(bus.out_mag), 0);
            chk({tag, "_inrdy_idle"}, 32'(bus.in_ready), 1);
        end
    endtask
    initial begin
        logic [WIDTH-1:0] dirs [6];
        int               seen;
        dirs = '{16'h0005, 16'hFFFB, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF};
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("rst_inrdy", 32'(bus.in_ready), 1);
        chk("rst_vld", 32'(bus.out_valid), 0);
        chk("rst_sign", 32'(bus.out_sign), 0);
        chk("rst_mag", 32'(bus.out_mag), 0);
        chk("rst_minneg", 32'(bus.out_minneg), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        bus.out_ready = 1'b1;
        foreach (dirs[i]) begin
            send(dirs[i]);
            recv($sformatf("dir_%h", dirs[i]));
        end
        // explicit constants for the extreme cases, independent of the model
        send(16'h8000);
        sb.delete();
        while (!bus.out_valid) step();
        chk("minneg_mag", 32'(bus.out_mag), 32'h8000);
        chk("minneg_flag", 32'(bus.out_minneg), 1);
        chk("minneg_sign", 32'(bus.out_sign), 1);
        step();
        send(16'hFFFB);
        sb.delete();
        while (!bus.out_valid) step();
        chk("m5_mag", 32'(bus.out_mag), 32'h0005);
        step();
        // backpressure with a competing input word
        bus.out_ready = 1'b0;
        send(16'hFF00);
        recv("bp");
        bus.in_data  = 16'h1234;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_vld", 32'(bus.out_valid), 1);
            chk("bp_sign", 32'(bus.out_sign), 1);
            chk("bp_mag", 32'(bus.out_mag), 32'h0100);
            chk("bp_inrdy", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("bp_release_vld", 32'(bus.out_valid), 0);
        chk("bp_release_inrdy", 32'(bus.in_ready), 1);
        step();
        chk("bp_no_second", 32'(bus.in_ready), 1);
        // reset in the middle of a conversion
        bus.out_ready = 1'b0;
        send(16'h8001);
        for (int k = 0; k < 6; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        chk("mid_rst_inrdy", 32'(bus.in_ready), 1);
        chk("mid_rst_vld", 32'(bus.out_valid), 0);
        chk("mid_rst_mag", 32'(bus.out_mag), 0);
        chk("mid_rst_sign", 32'(bus.out_sign), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            seen += int'(bus.out_valid);
        end
        chk("mid_rst_no_vld", seen, 0);
        // random sweep
        bus.out_ready = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            send(WIDTH'($urandom));
            recv("rnd");
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
